// File: rtl/i2c_slave.sv
// Single-address I2C target: oversamples SCL/SDA on clk, detects START/STOP,
// ACKs its address, then receives or transmits bytes through a pulse interface.
module i2c_slave #(
    parameter logic [6:0] SLAVE_ADDR  = 7'h5A,
    parameter int         SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sclk,
    input  logic       sda_in,
    output logic       sda_out,
    output logic [2:0] state,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic [7:0] tx_data,
    output logic       tx_load,
    output logic       addressed
);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        ADDR      = 3'd1,
        ADDR_ACK  = 3'd2,
        RX        = 3'd3,
        RX_ACK    = 3'd4,
        TX        = 3'd5,
        TX_ACK    = 3'd6,
        WAIT_STOP = 3'd7
    } state_t;

    state_t                 state_q, state_d;
    logic [SYNC_STAGES-1:0] scl_sync, sda_sync;
    logic                   scl_prev, sda_prev;
    logic                   scl_now, sda_now;
    logic                   scl_rise, scl_fall, start_det, stop_det;
    logic [2:0]             cnt_q, cnt_d;
    logic                   done_q, done_d;
    logic                   rw_q, rw_d;
    logic [7:0]             shift_q, shift_d;
    logic [7:0]             tx_shift_q, tx_shift_d;
    logic [7:0]             rx_data_d;
    logic                   rx_valid_d, tx_load_d, sda_d, addressed_d;

    // Synchronizers reset to the idle-bus level so reset never fakes an edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            scl_sync <= '1;
            sda_sync <= '1;
            scl_prev <= 1'b1;
            sda_prev <= 1'b1;
        end else begin
            scl_sync <= {scl_sync[SYNC_STAGES-2:0], sclk};
            sda_sync <= {sda_sync[SYNC_STAGES-2:0], sda_in};
            scl_prev <= scl_sync[SYNC_STAGES-1];
            sda_prev <= sda_sync[SYNC_STAGES-1];
        end
    end

    assign scl_now   = scl_sync[SYNC_STAGES-1];
    assign sda_now   = sda_sync[SYNC_STAGES-1];
    assign scl_rise  = !scl_prev && scl_now;
    assign scl_fall  = scl_prev && !scl_now;
    assign start_det = scl_prev && scl_now && sda_prev && !sda_now;
    assign stop_det  = scl_prev && scl_now && !sda_prev && sda_now;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= 3'd0;
            done_q     <= 1'b0;
            rw_q       <= 1'b0;
            shift_q    <= 8'h00;
            tx_shift_q <= 8'h00;
            rx_data    <= 8'h00;
            rx_valid   <= 1'b0;
            tx_load    <= 1'b0;
            sda_out    <= 1'b1;
            addressed  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            done_q     <= done_d;
            rw_q       <= rw_d;
            shift_q    <= shift_d;
            tx_shift_q <= tx_shift_d;
            rx_data    <= rx_data_d;
            rx_valid   <= rx_valid_d;
            tx_load    <= tx_load_d;
            sda_out    <= sda_d;
            addressed  <= addressed_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        done_d      = done_q;
        rw_d        = rw_q;
        shift_d     = shift_q;
        tx_shift_d  = tx_shift_q;
        rx_data_d   = rx_data;
        rx_valid_d  = 1'b0;
        tx_load_d   = 1'b0;
        sda_d       = sda_out;
        addressed_d = addressed;
        if (stop_det) begin
            state_d     = IDLE;
            sda_d       = 1'b1;
            addressed_d = 1'b0;
        end else if (start_det) begin
            state_d     = ADDR;
            cnt_d       = 3'd0;
            done_d      = 1'b0;
            sda_d       = 1'b1;
            addressed_d = 1'b0;
        end else begin
            // The done flag, not the 3-bit count, marks a full byte; the count wraps 7->0.
            if (scl_rise && (state_q == ADDR || state_q == RX || state_q == TX)) begin
                shift_d = {shift_q[6:0], sda_now};
                cnt_d   = cnt_q + 3'd1;
                if (cnt_q == 3'd7) done_d = 1'b1;
            end
            case (state_q)
                ADDR: if (scl_fall && done_q) begin
                    done_d = 1'b0;
                    rw_d   = shift_q[0];
                    if (shift_q[7:1] == SLAVE_ADDR) begin
                        sda_d       = 1'b0;
                        addressed_d = 1'b1;
                        state_d     = ADDR_ACK;
                    end else begin
                        sda_d   = 1'b1;
                        state_d = WAIT_STOP;
                    end
                end
                ADDR_ACK: if (scl_fall) begin
                    cnt_d  = 3'd0;
                    done_d = 1'b0;
                    if (rw_q) begin
                        tx_load_d  = 1'b1;
                        sda_d      = tx_data[7];
                        tx_shift_d = {tx_data[6:0], 1'b0};
                        state_d    = TX;
                    end else begin
                        sda_d   = 1'b1;
                        state_d = RX;
                    end
                end
                RX: if (scl_fall && done_q) begin
                    done_d     = 1'b0;
                    rx_data_d  = shift_q;
                    rx_valid_d = 1'b1;
                    sda_d      = 1'b0;
                    state_d    = RX_ACK;
                end
                RX_ACK: if (scl_fall) begin
                    sda_d   = 1'b1;
                    cnt_d   = 3'd0;
                    done_d  = 1'b0;
                    state_d = RX;
                end
                TX: if (scl_fall) begin
                    if (done_q) begin
                        done_d  = 1'b0;
                        sda_d   = 1'b1;
                        state_d = TX_ACK;
                    end else begin
                        sda_d      = tx_shift_q[7];
                        tx_shift_d = {tx_shift_q[6:0], 1'b0};
                    end
                end
                TX_ACK: begin
                    // A NACK leaves at once; an ACK waits for the fall to present the next byte.
                    if (scl_rise && sda_now) begin
                        state_d     = WAIT_STOP;
                        addressed_d = 1'b0;
                    end else if (scl_fall) begin
                        tx_load_d  = 1'b1;
                        sda_d      = tx_data[7];
                        tx_shift_d = {tx_data[6:0], 1'b0};
                        cnt_d      = 3'd0;
                        done_d     = 1'b0;
                        state_d    = TX;
                    end
                end
                default: sda_d = 1'b1;
            endcase
        end
    end

    assign state = state_q;

endmodule
